gpio_debounce: RTL

Per-pin input conditioning stage sitting directly upstream of the gpio block, between the IO pads and the gpio_i input of the GPIO peripheral.
- Synchronizes each raw pad input to clk_i.
- Rejects glitches shorter than a programmable number of cycles.
- Emits the filtered level plus a one-cycle change pulse per pin.
- Filtering is enabled per pin; disabled pins are passed through with fixed latency.

---
 rtl/gpio_debounce_pkg.sv | 15 +
 rtl/gpio_debounce_cell.sv | 102 ++++++++++
 rtl/prim_sync.sv | 29 ++
 rtl/gpio_debounce.sv | 74 +++++++
 4 files changed

// File: rtl/gpio_debounce_pkg.sv
// Purpose: shared types and defaults for the GPIO input debounce stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no handshakes).
package gpio_debounce_pkg;

    // Per-pin filter state: settled on gpio_o, or counting a candidate new level.
    typedef enum logic {
        DbncStable = 1'b0,
        DbncCheck  = 1'b1
    } dbnc_state_e;

    // Default width of the stability counter and the threshold input.
    localparam int unsigned DefCntWidth = 8;

endpackage

// File: rtl/gpio_debounce_cell.sv
// Purpose: one-pin glitch filter FSM with stability counter and registered level/change/busy outputs.
// Latency: 1 cycle in bypass; threshold cycles from first differing synchronized sample when filtering.
// Backpressure: none; i_tick gates counting in the check state only.
module gpio_debounce_cell
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned CntWidth = DefCntWidth
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_s,
    input  logic                i_filt_en,
    input  logic [CntWidth-1:0] i_threshold,
    input  logic                i_tick,
    output logic                o_gpio,
    output logic                o_change,
    output logic                o_busy
);

    dbnc_state_e         r_state;
    dbnc_state_e         w_state_nxt;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_nxt;
    logic                r_gpio;
    logic                w_gpio_nxt;
    logic                r_change;
    logic                r_busy;
    logic                w_bypass;
    logic [CntWidth:0]   w_cnt_inc;

    // A zero threshold means "no filtering", same as a disabled pin.
    assign w_bypass  = !i_filt_en || (i_threshold == '0);
    // One extra bit so cnt+1 can never wrap before the compare.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CntWidth{1'b0}}, 1'b1};

    // Next-state, counter and committed level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gpio_nxt  = r_gpio;
        if (w_bypass) begin
            w_state_nxt = DbncStable;
            w_cnt_nxt   = '0;
            w_gpio_nxt  = i_s;
        end else begin
            case (r_state)
                DbncStable: begin
                    w_cnt_nxt = '0;
                    if (i_s != r_gpio) begin
                        if (i_threshold == CntWidth'(1)) begin
                            w_gpio_nxt = i_s;
                        end else begin
                            w_state_nxt = DbncCheck;
                            w_cnt_nxt   = CntWidth'(1);
                        end
                    end
                end
                DbncCheck: begin
                    if (i_s == r_gpio) begin
                        // Input fell back before it was stable long enough.
                        w_state_nxt = DbncStable;
                        w_cnt_nxt   = '0;
                    end else if (i_tick) begin
                        if (w_cnt_inc >= {1'b0, i_threshold}) begin
                            w_gpio_nxt  = i_s;
                            w_state_nxt = DbncStable;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[CntWidth-1:0];
                        end
                    end
                end
                default: begin
                    w_state_nxt = DbncStable;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, level and the registered change/busy flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= DbncStable;
            r_cnt    <= '0;
            r_gpio   <= 1'b0;
            r_change <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gpio   <= w_gpio_nxt;
            r_change <= (w_gpio_nxt != r_gpio);
            r_busy   <= (w_state_nxt == DbncCheck);
        end
    end

    assign o_gpio   = r_gpio;
    assign o_change = r_change;
    assign o_busy   = r_busy;

endmodule

// File: rtl/prim_sync.sv
// Purpose: multi-flop synchronizer bringing one asynchronous bit into the clock domain.
// Latency: NrStages cycles.
// Backpressure: none; samples every cycle.
module prim_sync #(
    parameter int unsigned NrStages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [NrStages-1:0] r_stage;

    // Shift the raw input through the synchronizer chain; async clear to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < NrStages; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[NrStages-1];

endmodule

// File: rtl/gpio_debounce.sv
// Purpose: per-pin pad synchronizer plus glitch filter feeding the GPIO block (prescaler under GPIO_DEBOUNCE_PRESCALE_EN).
// Latency: NrSyncStages + threshold_i cycles filtered; NrSyncStages + 1 cycles in bypass.
// Backpressure: none; every pin is sampled every cycle and pins are independent.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned GpioCount    = 16,
    parameter int unsigned NrSyncStages = 2,
    parameter int unsigned CntWidth     = DefCntWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [GpioCount-1:0] gpio_i,
    input  logic [GpioCount-1:0] filt_en_i,
    input  logic [CntWidth-1:0]  threshold_i,
`ifdef GPIO_DEBOUNCE_PRESCALE_EN
    input  logic [CntWidth-1:0]  prescale_i,
`endif
    output logic [GpioCount-1:0] gpio_o,
    output logic [GpioCount-1:0] change_o,
    output logic [GpioCount-1:0] busy_o
);

    logic                 w_rst_n;
    logic                 w_tick;
    logic [GpioCount-1:0] w_sync;

    assign w_rst_n = ~rst_i;

`ifdef GPIO_DEBOUNCE_PRESCALE_EN
    logic [CntWidth-1:0] r_presc;

    assign w_tick = (r_presc == prescale_i);

    // Shared free-running prescaler; wraps to 0 on the tick cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CntWidth'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    for (genvar g = 0; g < GpioCount; g++) begin : g_pin
        prim_sync #(
            .NrStages (NrSyncStages)
        ) u_sync (
            .i_clk   (clk_i),
            .i_rst_n (w_rst_n),
            .i_d     (gpio_i[g]),
            .o_q     (w_sync[g])
        );

        gpio_debounce_cell #(
            .CntWidth (CntWidth)
        ) u_cell (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_s         (w_sync[g]),
            .i_filt_en   (filt_en_i[g]),
            .i_threshold (threshold_i),
            .i_tick      (w_tick),
            .o_gpio      (gpio_o[g]),
            .o_change    (change_o[g]),
            .o_busy      (busy_o[g])
        );
    end

endmodule
